spi_slave: RTL and testbench
============================

# spi_slave

Byte-oriented SPI responder (CPOL=0, CPHA selectable) clocked entirely from the system clock. It is the target-side counterpart of the TS-Conf SPI master and lets an external SPI initiator, such as an MCU or a second board, exchange bytes with the Z80/DMA side. SCK, SS_N and MOSI are oversampled and synchronised. Received bytes are presented with a one-clock strobe, and transmit bytes come from a single-entry holding register.

## Interface
- `FILL`, 8'hFF: byte shifted out when the TX holding register is empty at byte start.
- `clk`  in  1  system clock; must be ≥ 8× SCK frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `sck`  in  1  SPI clock from initiator (async).
- `ss_n`  in  1  slave select, active low (async).
- `mosi`  in  1  data from initiator (async).
- `miso`  out  1  data to initiator.
- `miso_oe`  out  1  MISO output enable, high only while selected.
- `mode`  in  1  0 = CPHA0/CPOL0, 1 = CPHA1/CPOL0; sampled at selection and held for the frame.
- `tx_din`  in  8  byte to transmit.
- `tx_wr`  in  1  write strobe for `tx_din`.
- `tx_full`  out  1  holding register occupied.
- `rx_dout`  out  8  last complete received byte.
- `rx_stb`  out  1  one-clock pulse when `rx_dout` updates.
- `sel`  out  1  synchronised, active-high select.

## Operation
- Synchronisers: 2 flops on each of sck, ss_n and mosi, plus a third sck/ss_n stage for edge detection. All logic uses the synchronised copies.
- States:
  - IDLE: ss inactive.
  - LOAD: one clock; latch mode, load shifter, bit count = 0.
  - SHIFT: bits in progress.
- IDLE→LOAD on synced ss_n falling edge. LOAD→SHIFT unconditionally. SHIFT→IDLE on synced ss_n rising edge, from any bit position.
- Load: shifter ← holding register if `tx_full`, else FILL. `tx_full` clears in the same clock.
- Mode 0:
  - `miso` = shifter[7] from LOAD onward.
  - Sample mosi on sck rising; shift left on sck falling.
- Mode 1:
  - On sck rising, drive shifter[7] and shift.
  - On sck falling, sample mosi.
- Bit count increments on each sample edge. On the 8th sample:
  - `rx_dout` ← {7 previously sampled bits, mosi}.
  - `rx_stb`=1 for one clock.
  - Bit count wraps to 0, and the shifter reloads per the load rule on the next shift edge (mode 0) or immediately (mode 1 also reloads then).
- Frames of any number of whole bytes are allowed.
- ss deassert mid-byte: discard partial byte, no `rx_stb`, `miso_oe`←0, a byte already loaded is not returned to the holding register.
- `tx_wr`:
  - Writes the holding register and sets `tx_full`.
  - Write while full overwrites the previous byte.
  - `tx_wr` in the same clock as a load: the load takes the old content (or FILL), then the new byte is stored and `tx_full` stays 1.
- SCK edges while IDLE are ignored.

## Timing
- Reset values: `miso`=1, `miso_oe`=0, `tx_full`=0, `rx_dout`=8'h00, `rx_stb`=0, `sel`=0, state IDLE, shifter=FILL.
- Edge-to-action latency: a pin edge is acted on in the 3rd clk after it is registered by the first sync flop.
- `rx_stb` asserts in that same clock as the 8th sample. `rx_dout` is valid from the same clock and holds until the next strobe.
- `sel`/`miso_oe` rise 3 clocks after ss_n falls and drop 3 clocks after it rises.
- Mode 0 minimum setup: the initiator must wait ≥ 4 clk between ss_n fall and the first sck rise.

## Structure
- Shared package `spi_pkg`:
  - mode encodings SPI_CPHA0 = 1'b0 and SPI_CPHA1 = 1'b1.
  - default fill 8'hFF.
  - state encoding IDLE/LOAD/SHIFT.
- One sub-module, `spi_sync`: 3-flop synchroniser with rise/fall pulse outputs. It has async reset to a parameterised level (1 for sck is wrong: sck resets to 0, ss_n resets to 1) and is instantiated three times.

## Test plan
- Mode 0, `tx_wr` 8'hA5 before select, initiator sends 8'h3C → miso shifts 1,0,1,0,0,1,0,1; `rx_dout`=8'h3C with one `rx_stb`; `tx_full` clears at select.
- Mode 1, same data → identical bytes both directions; miso changes only after sck rising edges.
- Two-byte frame, only one byte written → second byte out is 8'hFF; two `rx_stb` pulses with 8'h01 then 8'h80.
- ss_n released after 5 bits → no `rx_stb`, `miso_oe`=0 within 3 clocks, next frame receives 8'h55 correctly.
- `tx_wr` 8'h11 then 8'h22 while full → 8'h22 transmitted; `tx_wr` coincident with load → old byte sent, new byte pending, `tx_full`=1.
- `rst` asserted mid-byte → all outputs at reset values immediately; after release with ss still low, no strobe until a new ss_n falling edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and load rule for the SPI target.
package spi_pkg;

  localparam logic       SPI_CPHA0 = 1'b0;
  localparam logic       SPI_CPHA1 = 1'b1;
  localparam logic [7:0] SPI_FILL  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_t;

  // Byte handed to the shifter at a byte boundary.
  function automatic logic [7:0] load_byte(input logic full, input logic [7:0] hold);
    return full ? hold : SPI_FILL;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Host-side byte bus of the SPI target: TX holding register write and RX strobe.
interface spi_slave_if;

  logic [7:0] tx_din;
  logic       tx_wr;
  logic       tx_full;
  logic [7:0] rx_dout;
  logic       rx_stb;

  modport master (output tx_din, tx_wr, input tx_full, rx_dout, rx_stb);
  modport slave  (input tx_din, tx_wr, output tx_full, rx_dout, rx_stb);

endinterface

// File: rtl/spi_sync.sv
// Three-flop synchroniser; level taken after two flops, third flop gives edge pulses.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {3{RESET_VAL}};
    else     sync_q <= sync_d;
  end

  assign dout = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI target (CPOL=0, CPHA selectable), fully oversampled on clk.
// Received bytes strobe out on the bus; TX bytes come from a single-entry holding register.
module spi_slave
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       mode,
  output logic       miso,
  output logic       miso_oe,
  output logic       sel,
  spi_slave_if.slave bus
);

  localparam logic [1:0] SETTLE_DONE = 2'd2;

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck), .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(ss_n), .dout(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{sck_lvl, mosi_rise, mosi_fall};

  spi_state_t state_q, state_d;
  logic       mode_q, mode_d;
  logic [7:0] shifter_q, shifter_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       reload_q, reload_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       sel_q, sel_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_dout_q, rx_dout_d;
  logic       rx_stb_q, rx_stb_d;
  logic [1:0] settle_q, settle_d;
  logic       arm_q, arm_d;
  logic       take_tx;
  logic       sample_edge, shift_edge;
  logic [7:0] load_val;

  assign sample_edge = (mode_q == SPI_CPHA0) ? sck_rise : sck_fall;
  assign shift_edge  = (mode_q == SPI_CPHA0) ? sck_fall : sck_rise;
  assign load_val    = load_byte(tx_full_q, hold_q);

  // A select already low when reset releases must not start a frame: ss must be seen high first.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shifter_d = shifter_q;
    rx_sh_d   = rx_sh_q;
    bit_cnt_d = bit_cnt_q;
    reload_d  = reload_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    sel_d     = sel_q;
    rx_dout_d = rx_dout_q;
    rx_stb_d  = 1'b0;
    take_tx   = 1'b0;
    settle_d  = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 2'd1;
    arm_d     = arm_q | ((settle_q == SETTLE_DONE) & ss_lvl);

    case (state_q)
      IDLE: begin
        if (ss_fall && arm_q) begin
          state_d = LOAD;
          sel_d   = 1'b1;
          oe_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d   = SHIFT;
        mode_d    = mode;
        take_tx   = 1'b1;
        shifter_d = load_val;
        bit_cnt_d = 3'd0;
        reload_d  = 1'b0;
        miso_d    = (mode == SPI_CPHA0) ? load_val[7] : 1'b1;
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d  = IDLE;
          sel_d    = 1'b0;
          oe_d     = 1'b0;
          miso_d   = 1'b1;
          reload_d = 1'b0;
        end else if (sample_edge) begin
          rx_sh_d   = {rx_sh_q[5:0], mosi_lvl};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_dout_d = {rx_sh_q, mosi_lvl};
            rx_stb_d  = 1'b1;
            if (mode_q == SPI_CPHA0) begin
              reload_d = 1'b1;
            end else begin
              take_tx   = 1'b1;
              shifter_d = load_val;
            end
          end
        end else if (shift_edge) begin
          if (mode_q == SPI_CPHA1) begin
            miso_d    = shifter_q[7];
            shifter_d = {shifter_q[6:0], 1'b1};
          end else if (reload_q) begin
            take_tx   = 1'b1;
            shifter_d = load_val;
            miso_d    = load_val[7];
            reload_d  = 1'b0;
          end else begin
            shifter_d = {shifter_q[6:0], 1'b1};
            miso_d    = shifter_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A write in the load clock lands after the shifter has taken the old content.
    hold_d    = hold_q;
    tx_full_d = take_tx ? 1'b0 : tx_full_q;
    if (bus.tx_wr) begin
      hold_d    = bus.tx_din;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= SPI_CPHA0;
      shifter_q <= SPI_FILL;
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      reload_q  <= 1'b0;
      miso_q    <= 1'b1;
      oe_q      <= 1'b0;
      sel_q     <= 1'b0;
      hold_q    <= '0;
      tx_full_q <= 1'b0;
      rx_dout_q <= '0;
      rx_stb_q  <= 1'b0;
      settle_q  <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shifter_q <= shifter_d;
      rx_sh_q   <= rx_sh_d;
      bit_cnt_q <= bit_cnt_d;
      reload_q  <= reload_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      tx_full_q <= tx_full_d;
      rx_dout_q <= rx_dout_d;
      rx_stb_q  <= rx_stb_d;
      settle_q  <= settle_d;
      arm_q     <= arm_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign sel         = sel_q;
  assign bus.tx_full = tx_full_q;
  assign bus.rx_dout = rx_dout_q;
  assign bus.rx_stb  = rx_stb_q;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: an SPI initiator model drives random frames, a scoreboard
// queue of expected received bytes is drained by a monitor on every rx_stb.
module tb_spi_slave;

  localparam int HALF_BIT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic mode = 1'b0;
  logic miso, miso_oe, sel;

  spi_slave_if bus();

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_exp_q[$];
  logic       m_full;
  logic [7:0] m_hold;
  logic       mode1_frame = 1'b0;

  logic       prev_stb = 1'b0;
  logic       prev_miso = 1'b1;
  logic       prev_oe = 1'b0;
  logic       prev_sck = 1'b0;
  int         since_rise = 100;
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .ss_n(ss_n),
    .mosi(mosi),
    .mode(mode),
    .miso(miso),
    .miso_oe(miso_oe),
    .sel(sel),
    .bus(bus)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n clocks and land just after the falling edge, away from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Holding-register model: byte handed out at every byte start.
  function automatic logic [7:0] model_take();
    logic [7:0] b;
    b = m_full ? m_hold : 8'hFF;
    m_full = 1'b0;
    return b;
  endfunction

  task automatic check_reset_values(input string tag);
    check_output({tag, "_miso"}, miso, 1);
    check_output({tag, "_miso_oe"}, miso_oe, 0);
    check_output({tag, "_tx_full"}, bus.tx_full, 0);
    check_output({tag, "_rx_dout"}, bus.rx_dout, 0);
    check_output({tag, "_rx_stb"}, bus.rx_stb, 0);
    check_output({tag, "_sel"}, sel, 0);
  endtask

  task automatic write_tx(input logic [7:0] v);
    bus.tx_din = v;
    bus.tx_wr  = 1'b1;
    step(1);
    bus.tx_wr = 1'b0;
    m_hold = v;
    m_full = 1'b1;
    check_output("tx_full_after_wr", bus.tx_full, 1);
  endtask

  task automatic shift_bit(input logic m, input logic b, output logic got);
    if (m == 1'b0) begin
      mosi = b;
      step(HALF_BIT);
      got = miso;
      sck = 1'b1;
      step(HALF_BIT);
      sck = 1'b0;
    end else begin
      sck  = 1'b1;
      mosi = b;
      step(HALF_BIT);
      got = miso;
      sck = 1'b0;
      step(HALF_BIT);
    end
  endtask

  // One frame: nbytes whole bytes, or part_bits bits of a single aborted byte.
  task automatic apply_stimulus(input logic m, input int nbytes, input logic [7:0] data [3],
                                input bit wr_at_load, input logic [7:0] wr_val, input int part_bits);
    logic [7:0] tx_cur;
    logic [7:0] got_byte;
    logic       g;
    got_byte    = 8'h00;
    mode        = m;
    mode1_frame = m;
    ss_n        = 1'b0;
    step(2);
    check_output("sel_before_3clk", sel, 0);
    step(1);
    check_output("sel_at_3clk", sel, 1);
    check_output("miso_oe_at_3clk", miso_oe, 1);
    check_output("tx_full_before_load", bus.tx_full, m_full);
    if (wr_at_load) begin
      bus.tx_din = wr_val;
      bus.tx_wr  = 1'b1;
    end
    tx_cur = model_take();
    if (wr_at_load) begin
      m_hold = wr_val;
      m_full = 1'b1;
    end
    step(1);
    bus.tx_wr = 1'b0;
    check_output("tx_full_at_load", bus.tx_full, m_full);
    step(2);
    if (part_bits > 0) begin
      for (int i = 0; i < part_bits; i++) shift_bit(m, data[0][7-i], g);
    end else begin
      for (int b = 0; b < nbytes; b++) begin
        rx_exp_q.push_back(data[b]);
        for (int i = 0; i < 8; i++) begin
          shift_bit(m, data[b][7-i], g);
          got_byte[7-i] = g;
        end
        check_output("miso_byte", got_byte, tx_cur);
        tx_cur = model_take();
      end
    end
    step(HALF_BIT);
    ss_n = 1'b1;
    step(3);
    check_output("miso_oe_after_release", miso_oe, 0);
    check_output("sel_after_release", sel, 0);
    check_output("tx_full_after_frame", bus.tx_full, m_full);
    mode1_frame = 1'b0;
    step(4);
  endtask

  // Scoreboard monitor: pops one expected byte per strobe, also watches mode-1 MISO timing.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (prev_stb) check_output("rx_stb_width", bus.rx_stb, 0);
      if (bus.rx_stb === 1'b1) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rx_unexpected_stb actual=%0h required=none at %0t", bus.rx_dout, $time);
        end else begin
          mon_exp = rx_exp_q.pop_front();
          check_output("rx_dout", bus.rx_dout, mon_exp);
        end
      end
      if (sck && !prev_sck) since_rise = 0;
      else if (since_rise < 100) since_rise++;
      if (mode1_frame && miso_oe && prev_oe && (miso !== prev_miso))
        check_output("mode1_miso_after_rise", since_rise <= 4, 1);
      prev_stb  = bus.rx_stb;
      prev_miso = miso;
      prev_oe   = miso_oe;
      prev_sck  = sck;
    end
  end

  initial begin : stimulus
    logic [7:0] d [3];
    logic       g;
    logic       rm;
    int         nw, nb, pb;
    bit         wl;
    bus.tx_din = 8'h00;
    bus.tx_wr  = 1'b0;
    m_full     = 1'b0;
    m_hold     = 8'h00;

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
    check_reset_values("por");

    $display("[TB] mode 0 single byte");
    write_tx(8'hA5);
    d = '{8'h3C, 8'h00, 8'h00};
    apply_stimulus(1'b0, 1, d, 1'b0, 8'h00, 0);

    $display("[TB] mode 1 single byte");
    write_tx(8'hA5);
    apply_stimulus(1'b1, 1, d, 1'b0, 8'h00, 0);

    $display("[TB] two-byte frames with one byte written");
    write_tx(8'h5A);
    d = '{8'h01, 8'h80, 8'h00};
    apply_stimulus(1'b0, 2, d, 1'b0, 8'h00, 0);
    write_tx(8'hC6);
    apply_stimulus(1'b1, 2, d, 1'b0, 8'h00, 0);

    $display("[TB] aborted byte then recovery");
    d = '{8'hAA, 8'h00, 8'h00};
    apply_stimulus(1'b0, 1, d, 1'b0, 8'h00, 5);
    d = '{8'h55, 8'h00, 8'h00};
    apply_stimulus(1'b0, 1, d, 1'b0, 8'h00, 0);

    $display("[TB] overwrite and write coincident with load");
    write_tx(8'h11);
    write_tx(8'h22);
    d = '{8'hC3, 8'h00, 8'h00};
    apply_stimulus(1'b0, 1, d, 1'b0, 8'h00, 0);
    write_tx(8'h33);
    d = '{8'h0F, 8'hF0, 8'h00};
    apply_stimulus(1'b0, 2, d, 1'b1, 8'h44, 0);
    write_tx(8'h66);
    apply_stimulus(1'b1, 2, d, 1'b1, 8'h99, 0);

    $display("[TB] random frames");
    for (int k = 0; k < 24; k++) begin
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) write_tx(8'($urandom));
      for (int j = 0; j < 3; j++) d[j] = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 3));
      wl = ($urandom_range(0, 3) == 0);
      pb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      apply_stimulus(rm, nb, d, wl, 8'($urandom), pb);
    end

    $display("[TB] reset in the middle of a byte");
    write_tx(8'h77);
    mode = 1'b0;
    ss_n = 1'b0;
    step(6);
    for (int i = 0; i < 3; i++) shift_bit(1'b0, 1'b1, g);
    sck = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_byte");
    m_full = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    sck = 1'b0;
    for (int i = 0; i < 8; i++) shift_bit(1'b0, 1'($urandom), g);
    check_output("sel_after_rst_ss_low", sel, 0);
    check_output("miso_oe_after_rst_ss_low", miso_oe, 0);
    ss_n = 1'b1;
    step(6);
    d = '{8'h55, 8'h00, 8'h00};
    apply_stimulus(1'b0, 1, d, 1'b0, 8'h00, 0);

    step(10);
    check_output("rx_missing_strobes", rx_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
